// File: rtl/vtw_edge_sched.sv
// vtw_edge_sched -- per-channel edge scheduler for a tester pin.
//
// Each tester cycle (cycle_start_i) replays a small table of timed edges.
// Drive edges set the pin driver; compare edges open a strobe or window
// that checks chan_in_i/chan_mid_i and reports mismatches.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_we_i/addr/time/action  edge-table write (honoured only while idle)
//   cfg_edge_num_i        active edge count, sampled on cycle_start_i
//   cycle_start_i         tester-cycle start pulse
//   vector_number_i       current vector, sampled on cycle_start_i
//   chan_in_i, chan_mid_i pin level / pin at mid level
//   drive_en_o, drive_val_o   driver control
//   cmp_active_o          compare window open
//   fail_o, fail_count_o  mismatch pulse and saturating count
//   busy_o, overrun_o     running, sticky cycle_start-while-running
//
// Optional: define VTW_EDGE_SCHED_FAIL_LOG_EN to add first_fail_valid_o,
// first_fail_vector_o and first_fail_tick_o (first mismatch since reset).
//
// State | meaning
// IDLE  | waiting for cycle_start, table writable
// RUN   | stepping through the edge table against the tick counter
module vtw_edge_sched #(
  parameter int NUM_EDGES = 4,
  parameter int TIME_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [2:0]        cfg_addr_i,
  input  logic [TIME_W-1:0] cfg_time_i,
  input  logic [3:0]        cfg_action_i,
  input  logic [3:0]        cfg_edge_num_i,
  input  logic              cycle_start_i,
  input  logic [31:0]       vector_number_i,
  input  logic              chan_in_i,
  input  logic              chan_mid_i,
  output logic              drive_en_o,
  output logic              drive_val_o,
  output logic              cmp_active_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  fail_count_o,
  output logic              busy_o,
  output logic              overrun_o
`ifdef VTW_EDGE_SCHED_FAIL_LOG_EN
  ,
  output logic              first_fail_valid_o,
  output logic [31:0]       first_fail_vector_o,
  output logic [TIME_W-1:0] first_fail_tick_o
`endif
);

  localparam int IW    = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1;
  localparam int DEPTH = 1 << IW;
  localparam logic [3:0]        NUM_EDGES_C = 4'(NUM_EDGES);
  localparam logic [TIME_W-1:0] TICK_MAX    = '1;
  localparam logic [TIME_W-1:0] TICK_ONE    = 1;
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {EXP_LOW, EXP_HIGH, EXP_MID} exp_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] tick_q, tick_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              drive_en_q, drive_en_d;
  logic              drive_val_q, drive_val_d;
  logic              cmp_active_q, cmp_active_d;
  logic              win_mode_q, win_mode_d;
  exp_e              exp_q, exp_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  fail_count_q, fail_count_d;
  logic              overrun_q, overrun_d;

  logic [TIME_W-1:0] edge_time_q [DEPTH];
  logic [3:0]        edge_act_q  [DEPTH];

  logic [TIME_W-1:0] cur_time;
  logic [3:0]        cur_act;
  logic [3:0]        num_clamped;
  logic              exec;
  logic              mismatch;
  logic              run;
  logic              addr_ok;

  assign run         = (state_q == S_RUN);
  assign num_clamped = (cfg_edge_num_i > NUM_EDGES_C) ? NUM_EDGES_C : cfg_edge_num_i;
  assign addr_ok     = ({1'b0, cfg_addr_i} < NUM_EDGES_C);
  assign cur_time    = edge_time_q[idx_q[IW-1:0]];
  assign cur_act     = edge_act_q[idx_q[IW-1:0]];

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    drive_en_d   = drive_en_q;
    drive_val_d  = drive_val_q;
    cmp_active_d = cmp_active_q;
    win_mode_d   = win_mode_q;
    exp_d        = exp_q;
    overrun_d    = overrun_q;
    fail_count_d = fail_count_q;
    mismatch     = 1'b0;

    // A cycle_start closes any open window without checking it.
    if (cmp_active_q && !cycle_start_i) begin
      case (exp_q)
        EXP_LOW:  mismatch = chan_mid_i | chan_in_i;
        EXP_HIGH: mismatch = chan_mid_i | ~chan_in_i;
        default:  mismatch = ~chan_mid_i;
      endcase
    end
    fail_d = mismatch;
    if (mismatch && (fail_count_q != CNT_MAX)) fail_count_d = fail_count_q + CNT_ONE;
    if (cycle_start_i || mismatch || !win_mode_q) cmp_active_d = 1'b0;

    if (run && (tick_q != TICK_MAX)) tick_d = tick_q + TICK_ONE;
    if (run && (idx_q == cnt_q)) state_d = S_IDLE;

    // One edge per clock; a late edge simply executes on the next clock.
    exec = run && !cycle_start_i && (idx_q != cnt_q) && (tick_q >= cur_time);
    if (exec) begin
      idx_d = idx_q + 4'd1;
      case (cur_act[2:0])
        3'd1, 3'd2: begin
          drive_en_d   = 1'b1;
          drive_val_d  = cur_act[1];
          cmp_active_d = 1'b0;
        end
        3'd3: begin
          drive_en_d   = 1'b0;
          cmp_active_d = 1'b0;
        end
        3'd4, 3'd5, 3'd6: begin
          exp_d        = (cur_act[2:0] == 3'd4) ? EXP_LOW :
                         (cur_act[2:0] == 3'd5) ? EXP_HIGH : EXP_MID;
          cmp_active_d = 1'b1;
          win_mode_d   = cur_act[3];
        end
        3'd7:    cmp_active_d = 1'b0;
        default: ;
      endcase
    end

    if (cycle_start_i) begin
      if (run) overrun_d = 1'b1;
      cnt_d   = num_clamped;
      tick_d  = '0;
      idx_d   = '0;
      state_d = (num_clamped != 4'd0) ? S_RUN : S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      drive_en_q   <= 1'b0;
      drive_val_q  <= 1'b0;
      cmp_active_q <= 1'b0;
      win_mode_q   <= 1'b0;
      exp_q        <= EXP_LOW;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      drive_en_q   <= drive_en_d;
      drive_val_q  <= drive_val_d;
      cmp_active_q <= cmp_active_d;
      win_mode_q   <= win_mode_d;
      exp_q        <= exp_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      overrun_q    <= overrun_d;
    end
  end

  // Writes land even when cycle_start is in the same clock, so the new
  // cycle already sees them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        edge_time_q[i] <= '0;
        edge_act_q[i]  <= '0;
      end
    end else if (cfg_we_i && !run && addr_ok) begin
      edge_time_q[cfg_addr_i[IW-1:0]] <= cfg_time_i;
      edge_act_q[cfg_addr_i[IW-1:0]]  <= cfg_action_i;
    end
  end

`ifdef VTW_EDGE_SCHED_FAIL_LOG_EN
  logic [31:0]       vector_q;
  logic              ff_valid_q;
  logic [31:0]       ff_vector_q;
  logic [TIME_W-1:0] ff_tick_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vector_q    <= '0;
      ff_valid_q  <= 1'b0;
      ff_vector_q <= '0;
      ff_tick_q   <= '0;
    end else begin
      if (cycle_start_i) vector_q <= vector_number_i;
      if (mismatch && !ff_valid_q) begin
        ff_valid_q  <= 1'b1;
        ff_vector_q <= vector_q;
        ff_tick_q   <= tick_q;
      end
    end
  end

  assign first_fail_valid_o  = ff_valid_q;
  assign first_fail_vector_o = ff_vector_q;
  assign first_fail_tick_o   = ff_tick_q;
`else
  logic unused_vector;
  assign unused_vector = ^vector_number_i;
`endif

  assign drive_en_o   = drive_en_q;
  assign drive_val_o  = drive_val_q;
  assign cmp_active_o = cmp_active_q;
  assign fail_o       = fail_q;
  assign fail_count_o = fail_count_q;
  assign busy_o       = run;
  assign overrun_o    = overrun_q;

endmodule

// File: doc/vtw_edge_sched.md
VTW_EDGE_SCHED -- requirements
Module: vtw_edge_sched

Interface
REQ-001 Parameter NUM_EDGES, 4, edge-table depth; legal values 1..8.
REQ-002 Parameter TIME_W, 8, width of the tick counter and of edge times.
REQ-003 Parameter CNT_W, 16, width of fail_count.
REQ-004 Port clk  in  1  scheduler clock; all logic is rising-edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port cfg_we  in  1  edge-table write strobe.
REQ-007 Port cfg_addr  in  3  edge index written; indices >= NUM_EDGES are ignored.
REQ-008 Port cfg_time  in  TIME_W  edge tick offset from cycle start.
REQ-009 Port cfg_action  in  4  bit3 = window mode; bits2:0 = 0 NOP, 1 DRIVE_LOW, 2 DRIVE_HIGH, 3 DRIVE_OFF, 4 CMP_LOW, 5 CMP_HIGH, 6 CMP_MID, 7 CMP_OFF.
REQ-010 Port cfg_edge_num  in  4  active edge count; sampled on cycle_start; values > NUM_EDGES clamp to NUM_EDGES.
REQ-011 Port cycle_start  in  1  one-clock tester-cycle start pulse.
REQ-012 Port vector_number  in  32  current vector; sampled on cycle_start.
REQ-013 Port chan_in  in  1  DUT pin logic level.
REQ-014 Port chan_mid  in  1  DUT pin at mid level / high-Z.
REQ-015 Port drive_en  out  1  driver enabled.
REQ-016 Port drive_val  out  1  driven level.
REQ-017 Port cmp_active  out  1  compare window open.
REQ-018 Port fail  out  1  one-clock pulse per detected mismatch.
REQ-019 Port fail_count  out  CNT_W  saturating mismatch count.
REQ-020 Port busy  out  1  state RUN.
REQ-021 Port overrun  out  1  sticky: cycle_start arrived while busy.

Function
REQ-022 States IDLE, RUN; IDLE->RUN on cycle_start with sampled edge count > 0; RUN->IDLE when edge index reaches sampled count.
REQ-023 cycle_start in clock T: tick=0 and idx=0 in T+1; tick increments by 1 each clock in RUN, saturating at all-ones.
REQ-024 At most one edge executes per clock: edge[idx] executes in the clock where tick >= edge_time[idx], then idx increments; equal or decreasing times therefore slip by one tick each.
REQ-025 Edge effects are registered: an edge executing in clock C changes outputs at C+1; edge time t with no slip changes outputs at T+2+t.
REQ-026 DRIVE_LOW/HIGH: drive_en=1, drive_val=0/1, cmp_active=0; DRIVE_OFF: drive_en=0, drive_val holds.
REQ-027 CMP_LOW/HIGH/MID sets expected to 0/1/mid and opens the window (cmp_active=1); window mode bit3=1 keeps it open until CMP_OFF, any DRIVE edge, a new compare edge, a mismatch or cycle_start; bit3=0 is a strobe, open exactly one clock.
REQ-028 Check every clock cmp_active=1: mismatch for LOW = chan_mid|chan_in, HIGH = chan_mid|~chan_in, MID = ~chan_mid.
REQ-029 Mismatch: fail=1 next clock, fail_count+1 saturating at all-ones, window closes; at most one fail per window.
REQ-030 Compare edge executing while drive_en=1 is still performed (driver-on compare is legal).
REQ-031 NOP and CMP_OFF with no window open consume a tick only.
REQ-032 drive_en/drive_val persist across tester cycles and through IDLE.
REQ-033 cycle_start while RUN: overrun=1 (sticky), open window closes without check, schedule restarts at idx 0 per REQ-023.
REQ-034 cfg_we while RUN is ignored; in IDLE it writes edge_time/edge_action at cfg_addr, visible from next cycle_start.
REQ-035 cfg_we and cycle_start in the same IDLE clock: write lands first, new cycle uses it.

Reset
REQ-036 rst returns to IDLE; tick, idx, drive_en, drive_val, cmp_active, fail, fail_count, busy, overrun = 0; all edges = time 0, action NOP.
REQ-037 rst mid-RUN aborts the cycle with no fail, no overrun and no further edge effects.

Configuration
REQ-038 Macro VTW_EDGE_SCHED_FAIL_LOG_EN defined: add outputs first_fail_valid (1), first_fail_vector (32), first_fail_tick (TIME_W), capturing vector_number and tick of the first mismatch after reset; held until rst.
REQ-039 Macro undefined: those ports and registers do not exist; all other behaviour identical.

Verification
REQ-040 Edges {2:DRIVE_HIGH,5:DRIVE_LOW}, count 2, cycle_start at T -> drive_val 1 at T+4, 0 at T+7; busy drops at T+8.
REQ-041 Edge {3:CMP_HIGH strobe}, chan_in=0 -> fail pulse at T+6, fail_count=1, cmp_active high only T+5.
REQ-042 Edges {1:CMP_LOW window,6:CMP_OFF}, chan_in rises at T+5 -> single fail at T+6; no second fail.
REQ-043 Edges {4,4,4} all DRIVE -> effects at T+6, T+7, T+8 (slip).
REQ-044 cycle_start at T and T+3 with edges at tick 10 -> overrun=1, edge effect only at T+15.
REQ-045 With VTW_EDGE_SCHED_FAIL_LOG_EN, fails at vectors 7 then 9 -> first_fail_vector=7, fail_count=2.
